// File: rtl/sbox_layer_serial.sv
// Serialised PRESENT 4-bit S-box layer: substitutes LANES nibbles per cycle, LSB group first.
// Optional macro SBOX_LAYER_INVERSE_EN adds the inverse table, selected per state at acceptance.
module sbox_layer_serial #(
  parameter int STATE_W = 64,
  parameter int LANES   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
  input  logic               inverse,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data,
  output logic               busy
);

  localparam int NIB   = STATE_W / 4;
  localparam int N     = NIB / LANES;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int GRP_W = LANES * 4;

  if ((STATE_W % 4) != 0 || LANES < 1 || (NIB % LANES) != 0) begin : g_bad_params
    $error("sbox_layer_serial: STATE_W must be a multiple of 4 and LANES must divide STATE_W/4");
  end

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
    case (x)
      4'h0: sbox_fwd = 4'hC;  4'h1: sbox_fwd = 4'h5;  4'h2: sbox_fwd = 4'h6;  4'h3: sbox_fwd = 4'hB;
      4'h4: sbox_fwd = 4'h9;  4'h5: sbox_fwd = 4'h0;  4'h6: sbox_fwd = 4'hA;  4'h7: sbox_fwd = 4'hD;
      4'h8: sbox_fwd = 4'h3;  4'h9: sbox_fwd = 4'hE;  4'hA: sbox_fwd = 4'hF;  4'hB: sbox_fwd = 4'h8;
      4'hC: sbox_fwd = 4'h4;  4'hD: sbox_fwd = 4'h7;  4'hE: sbox_fwd = 4'h1;  default: sbox_fwd = 4'h2;
    endcase
  endfunction

`ifdef SBOX_LAYER_INVERSE_EN
  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    case (x)
      4'h0: sbox_inv = 4'h5;  4'h1: sbox_inv = 4'hE;  4'h2: sbox_inv = 4'hF;  4'h3: sbox_inv = 4'h8;
      4'h4: sbox_inv = 4'hC;  4'h5: sbox_inv = 4'h1;  4'h6: sbox_inv = 4'h2;  4'h7: sbox_inv = 4'hD;
      4'h8: sbox_inv = 4'hB;  4'h9: sbox_inv = 4'h4;  4'hA: sbox_inv = 4'h6;  4'hB: sbox_inv = 4'h3;
      4'hC: sbox_inv = 4'h0;  4'hD: sbox_inv = 4'h7;  4'hE: sbox_inv = 4'h9;  default: sbox_inv = 4'hA;
    endcase
  endfunction

  logic mode_q, mode_d;
`else
  logic unused_inverse;
  assign unused_inverse = inverse;
`endif

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STATE_W-1:0] data_q, data_d;

  // The active group is shifted down to bit 0 so only LANES S-boxes exist, whatever N is.
  logic [31:0]        shamt;
  logic [STATE_W-1:0] shifted;
  logic [GRP_W-1:0]   grp_in, grp_out;
  logic [STATE_W-1:0] grp_mask;

  assign shamt    = 32'(cnt_q) * 32'(GRP_W);
  assign shifted  = data_q >> shamt;
  assign grp_in   = shifted[GRP_W-1:0];
  assign grp_mask = STATE_W'({GRP_W{1'b1}}) << shamt;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
`ifdef SBOX_LAYER_INVERSE_EN
    assign grp_out[l*4 +: 4] = mode_q ? sbox_inv(grp_in[l*4 +: 4]) : sbox_fwd(grp_in[l*4 +: 4]);
`else
    assign grp_out[l*4 +: 4] = sbox_fwd(grp_in[l*4 +: 4]);
`endif
  end

  // NOTE: every next-state signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
`ifdef SBOX_LAYER_INVERSE_EN
    mode_d  = mode_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          cnt_d   = '0;
          state_d = S_RUN;
`ifdef SBOX_LAYER_INVERSE_EN
          mode_d  = inverse;
`endif
        end
      end
      S_RUN: begin
        data_d = (data_q & ~grp_mask) | (STATE_W'(grp_out) << shamt);
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
`ifdef SBOX_LAYER_INVERSE_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
`ifdef SBOX_LAYER_INVERSE_EN
      mode_q  <= mode_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = data_q;

endmodule

// File: tb/tb_sbox_layer_serial.sv
// Self-checking bench for sbox_layer_serial: 64-bit/4-lane instance plus a 16-bit/1-lane instance.
module tb_sbox_layer_serial;

  localparam int W  = 64;
  localparam int NN = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, inverse, out_valid, out_ready, busy;
  logic [W-1:0]  in_data, out_data;
  logic          in_valid16, in_ready16, inverse16, out_valid16, out_ready16, busy16;
  logic [15:0]   in_data16, out_data16;

  int checks = 0;
  int errors = 0;

  sbox_layer_serial #(.STATE_W(64), .LANES(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .inverse(inverse),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  sbox_layer_serial #(.STATE_W(16), .LANES(1)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16), .inverse(inverse16),
    .out_valid(out_valid16), .out_ready(out_ready16), .out_data(out_data16), .busy(busy16)
  );

  always #5 clk = ~clk;

  logic [3:0] fwd_t [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                             4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  logic [3:0] inv_t [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                             4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};

  // Whole-state reference: every nibble mapped through the table the build actually provides.
  function automatic logic [63:0] model(input logic [63:0] d, input logic inv, input int nib);
    logic [63:0] r;
    logic [3:0]  x;
    logic        use_inv;
`ifdef SBOX_LAYER_INVERSE_EN
    use_inv = inv;
`else
    use_inv = 1'b0;
`endif
    r = '0;
    for (int i = 0; i < nib; i++) begin
      x = 4'(d >> (4 * i));
      r = r | (64'(use_inv ? inv_t[x] : fwd_t[x]) << (4 * i));
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [63:0] d, input logic inv, input logic [63:0] exp, input string name);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin step(); t++; end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s idle_wait: in_ready=%b required 1", name, in_ready);
    end
    in_valid = 1'b1; in_data = d; inverse = inv; out_ready = 1'b1;
    step();
    in_valid = 1'b0; in_data = {$urandom, $urandom}; inverse = 1'($urandom);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL %s run_flags: busy=%b in_ready=%b out_valid=%b required 1/0/0",
                         name, busy, in_ready, out_valid);
    end
    t = 0;
    while (!out_valid && t < 50) begin step(); t++; end
    checks++;
    if (t != NN) begin
      errors++; $display("FAIL %s latency: got %0d cycles required %0d", name, t, NN);
    end
    checks++;
    if (out_data !== exp) begin
      errors++; $display("FAIL %s data: got %h required %h", name, out_data, exp);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL %s release: out_valid=%b in_ready=%b busy=%b required 0/1/0",
                         name, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
      errors++; $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b out_data=%h required 1/0/0/0",
                         in_ready, out_valid, busy, out_data);
    end
  endtask

  task automatic test_forward();
    do_op(64'h0123456789ABCDEF, 1'b0, 64'hC56B90AD3EF84712, "fwd_vector");
    do_op(64'h0, 1'b0, 64'hCCCCCCCCCCCCCCCC, "fwd_zero");
    do_op(64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h2222222222222222, "fwd_ones");
  endtask

  task automatic test_inverse();
    do_op(64'hC56B90AD3EF84712, 1'b1, model(64'hC56B90AD3EF84712, 1'b1, 16), "inv_vector");
    do_op(64'h0123456789ABCDEF, 1'b1, model(64'h0123456789ABCDEF, 1'b1, 16), "inv_mode_input");
  endtask

  task automatic test_random();
    logic [63:0] d;
    logic        inv;
    for (int i = 0; i < 16; i++) begin
      d = {$urandom, $urandom};
      inv = 1'($urandom_range(0, 1));
      do_op(d, inv, model(d, inv, 16), "random");
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] d, exp, snap;
    int t;
    d = {$urandom, $urandom};
    exp = model(d, 1'b0, 16);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = d; inverse = 1'b0;
    step();
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 50) begin step(); t++; end
    snap = out_data;
    checks++;
    if (out_valid !== 1'b1 || snap !== exp) begin
      errors++; $display("FAIL bp_result: out_valid=%b data=%h required 1/%h", out_valid, snap, exp);
    end
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin in_valid = 1'b1; in_data = ~d; inverse = 1'b1; end
      step();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== snap) begin
        errors++; $display("FAIL bp_hold: cycle %0d out_valid=%b in_ready=%b data=%h required 1/0/%h",
                           c, out_valid, in_ready, out_data, snap);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_transfer: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_single: out_valid=%b busy=%b required 0/0", out_valid, busy);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_data = {$urandom, $urandom}; inverse = 1'b0; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_data !== '0) begin
      errors++; $display("FAIL reset_mid: out_valid=%b in_ready=%b busy=%b data=%h required 0/1/0/0",
                         out_valid, in_ready, busy, out_data);
    end
    #2 rst_n = 1'b1;
    step();
    do_op(64'h0123456789ABCDEF, 1'b0, 64'hC56B90AD3EF84712, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [63:0] v [3];
    logic [63:0] q [$];
    logic [63:0] e;
    int acc [3];
    int k, cyc;
    for (int i = 0; i < 3; i++) v[i] = {$urandom, $urandom};
    k = 0; cyc = 0;
    out_ready = 1'b1; inverse = 1'b0; in_valid = 1'b1;
    while ((k < 3 || q.size() > 0) && cyc < 200) begin
      if (out_valid && q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (out_data !== e) begin
          errors++; $display("FAIL b2b_data: got %h required %h", out_data, e);
        end
      end
      if (in_ready && k < 3) begin
        in_data = v[k]; acc[k] = cyc; q.push_back(model(v[k], 1'b0, 16)); k++;
      end else if (in_ready) begin
        in_valid = 1'b0;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (k != 3 || q.size() != 0) begin
      errors++; $display("FAIL b2b_timeout: accepted %0d pending %0d required 3/0", k, q.size());
    end else begin
      checks++;
      if (acc[1] - acc[0] != NN + 2 || acc[2] - acc[1] != NN + 2) begin
        errors++; $display("FAIL b2b_spacing: got %0d,%0d required %0d", acc[1] - acc[0], acc[2] - acc[1], NN + 2);
      end
    end
    step();
    step();
  endtask

  task automatic op16(input logic [15:0] d, input logic inv, input logic [15:0] exp, input string name);
    int t;
    in_valid16 = 1'b1; in_data16 = d; inverse16 = inv;
    step();
    in_valid16 = 1'b0;
    t = 0;
    while (!out_valid16 && t < 50) begin step(); t++; end
    checks++;
    if (t != 4 || out_data16 !== exp) begin
      errors++; $display("FAIL %s: latency %0d data %h required 4/%h", name, t, out_data16, exp);
    end
    step();
    checks++;
    if (in_ready16 !== 1'b1 || out_valid16 !== 1'b0) begin
      errors++; $display("FAIL %s release: in_ready=%b out_valid=%b required 1/0", name, in_ready16, out_valid16);
    end
  endtask

  task automatic test_lanes1();
    logic [15:0] d;
    logic        inv;
    op16(16'hFEDC, 1'b0, 16'h2174, "lanes1_vector");
    for (int i = 0; i < 4; i++) begin
      d = 16'($urandom);
      inv = 1'($urandom_range(0, 1));
      op16(d, inv, 16'(model(64'(d), inv, 4)), "lanes1_random");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; inverse = 1'b0; out_ready = 1'b1;
    in_valid16 = 1'b0; in_data16 = '0; inverse16 = 1'b0; out_ready16 = 1'b1;
    #2;
    test_reset();
    #10 rst_n = 1'b1;
    step();
    test_reset();
    test_forward();
    test_inverse();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_lanes1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
